// File: rtl/serial2_adder_ctrl_pkg.sv
// Shared definitions for the digit-serial adder front end: FSM encodings,
// digit size and the digit-counter width helper.
package serial2_adder_ctrl_pkg;

    localparam int DIGIT_BITS = 32'sd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter must hold 0..n-1 and never collapse to zero bits when n==1.
    function automatic int cnt_width(input int n);
        if (n > 32'sd1) begin
            return $clog2(n);
        end else begin
            return 32'sd1;
        end
    endfunction

endpackage

// File: rtl/serial2_adder_ctrl_add2_slice.sv
// Combinational 2-bit ripple-carry adder slice; one digit of the
// digit-serial datapath.
module add2_slice
    import serial2_adder_ctrl_pkg::*;
(
    input  logic [DIGIT_BITS-1:0] x,
    input  logic [DIGIT_BITS-1:0] y,
    input  logic                  ci,
    output logic [DIGIT_BITS-1:0] s,
    output logic                  co
);

    logic c0_s;

    assign s[0] = x[0] ^ y[0] ^ ci;
    assign c0_s = (x[0] & y[0]) | (ci & (x[0] ^ y[0]));
    assign s[1] = x[1] ^ y[1] ^ c0_s;
    assign co   = (x[1] & y[1]) | (c0_s & (x[1] ^ y[1]));

endmodule

// File: rtl/serial2_adder_ctrl.sv
// Digit-serial adder front end: feeds two operand bits per clock through
// add2_slice, carries between digits and shifts sum digits in from the MSB.
module serial2_adder_ctrl
    import serial2_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int N  = WIDTH / DIGIT_BITS;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 32'sd1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'sd1);

    logic [1:0]            state_r;
    logic [1:0]            state_nxt_s;
    logic [WIDTH-1:0]      ra_r;
    logic [WIDTH-1:0]      rb_r;
    logic                  carry_r;
    logic [CW-1:0]         count_r;
    logic [DIGIT_BITS-1:0] slice_sum_s;
    logic                  slice_co_s;
    logic [WIDTH-1:0]      sum_next_s;
    logic                  last_s;

    add2_slice u_slice (
        .x  (ra_r[DIGIT_BITS-1:0]),
        .y  (rb_r[DIGIT_BITS-1:0]),
        .ci (carry_r),
        .s  (slice_sum_s),
        .co (slice_co_s)
    );

    // New digit enters at the MSB end so the result is LSB-aligned after N shifts.
    generate
        if (WIDTH == DIGIT_BITS) begin : g_one_digit
            assign sum_next_s = slice_sum_s;
        end else begin : g_multi_digit
            assign sum_next_s = {slice_sum_s, sum[WIDTH-1:DIGIT_BITS]};
        end
    endgenerate

    assign last_s = (count_r == LAST_CNT);

    // Next-state decode for the IDLE -> RUN -> DONE sequencer.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, status flags, operand shifters, carry, counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            ra_r    <= '0;
            rb_r    <= '0;
            carry_r <= 1'b0;
            count_r <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy    <= (state_nxt_s == ST_RUN);
            done    <= (state_nxt_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        ra_r    <= a;
                        rb_r    <= b;
                        carry_r <= cin;
                        count_r <= '0;
                    end
                end
                ST_RUN: begin
                    carry_r <= slice_co_s;
                    sum     <= sum_next_s;
                    ra_r    <= ra_r >> DIGIT_BITS;
                    rb_r    <= rb_r >> DIGIT_BITS;
                    if (last_s) begin
                        cout <= slice_co_s;
                    end else begin
                        count_r <= count_r + CNT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial2_adder_ctrl.sv
// Randomized self-checking bench for serial2_adder_ctrl (WIDTH=8 and WIDTH=4),
// checked against plain-arithmetic expectations for sum, carry and timing.
module tb_serial2_adder_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    int n_total = 0;
    int n_bad   = 0;

    serial2_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial2_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic [7:0] av, input logic [7:0] bv,
                         input logic cv, input logic st);
        if (w == 8) begin
            a8 = av; b8 = bv; cin8 = cv; start8 = st;
        end else begin
            a4 = av[3:0]; b4 = bv[3:0]; cin4 = cv; start4 = st;
        end
    endtask

    function automatic logic get_busy(input int w);
        return (w == 8) ? busy8 : busy4;
    endfunction

    function automatic logic get_done(input int w);
        return (w == 8) ? done8 : done4;
    endfunction

    function automatic logic [31:0] get_sum(input int w);
        return (w == 8) ? {24'd0, sum8} : {28'd0, sum4};
    endfunction

    function automatic logic get_cout(input int w);
        return (w == 8) ? cout8 : cout4;
    endfunction

    // One addition from an IDLE negedge; operands and start are scrambled after accept.
    task automatic run_add(input int w, input logic [7:0] av, input logic [7:0] bv, input logic cv);
        int n        = w / 2;
        int exp_v    = int'(av) + int'(bv) + int'(cv);
        int mask     = (1 << w) - 1;
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = 0;
        logic st;
        drive(w, av, bv, cv, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 2) st = 1'b1;
            else if (k > 2 && k <= n + 1) st = 1'($urandom);
            else st = 1'b0;
            drive(w, 8'($urandom), 8'($urandom), 1'($urandom), st);
            if (get_busy(w)) busy_cnt++;
            if (get_done(w)) begin
                done_cnt++;
                if (done_at == 0) begin
                    done_at = k;
                    check("sum", get_sum(w), 32'(exp_v & mask));
                    check("cout", {31'd0, get_cout(w)}, 32'((exp_v >> w) & 1));
                end
            end
            if (done_at != 0 && k == done_at + 1) begin
                check("sum_hold", get_sum(w), 32'(exp_v & mask));
                break;
            end
        end
        check("busy_cycles", 32'(busy_cnt), 32'(n));
        check("done_latency", 32'(done_at), 32'(n + 1));
        check("done_count", 32'(done_cnt), 32'd1);
    endtask

    // start held high: accepts at every 6th negedge, results 5 negedges later.
    task automatic stream8();
        int exp_q[3];
        for (int m = 0; m < 18; m++) begin
            logic [7:0] av = 8'($urandom);
            logic [7:0] bv = 8'($urandom);
            logic       cv = 1'($urandom);
            drive(8, av, bv, cv, 1'b1);
            if (m % 6 == 0) exp_q[m / 6] = int'(av) + int'(bv) + int'(cv);
            @(negedge clk);
            check("stream_done", {31'd0, done8}, {31'd0, ((m + 1) % 6 == 5)});
            if ((m + 1) % 6 == 5) begin
                check("stream_sum", {24'd0, sum8}, 32'(exp_q[m / 6] & 255));
                check("stream_cout", {31'd0, cout8}, 32'((exp_q[m / 6] >> 8) & 1));
            end
        end
        drive(8, 8'd0, 8'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(8, 8'd0, 8'd0, 1'b0, 1'b0);
        drive(4, 8'd0, 8'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_busy8", {31'd0, busy8}, 32'd0);
        check("rst_done8", {31'd0, done8}, 32'd0);
        check("rst_sum8", {24'd0, sum8}, 32'd0);
        check("rst_cout8", {31'd0, cout8}, 32'd0);
        check("rst_sum4", {28'd0, sum4}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_add(8, 8'h0F, 8'h01, 1'b0);
        run_add(8, 8'hFF, 8'h01, 1'b0);
        run_add(8, 8'hFF, 8'hFF, 1'b1);
        run_add(8, 8'h12, 8'h34, 1'b0);

        // Asynchronous reset two cycles into RUN.
        drive(8, 8'hFF, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        drive(8, 8'hFF, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy8}, 32'd0);
        check("arst_done", {31'd0, done8}, 32'd0);
        check("arst_sum", {24'd0, sum8}, 32'd0);
        check("arst_cout", {31'd0, cout8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_add(8, 8'h80, 8'h80, 1'b0);

        stream8();
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            run_add(8, 8'($urandom), 8'($urandom), 1'($urandom));
        end

        for (int ab = 0; ab < 512; ab++) begin
            run_add(4, 8'(ab & 15), 8'((ab >> 4) & 15), 1'(ab >> 8));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
